// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters, for example
// the execute stage (port 0) and the branch-resolution unit (port 1).
// Requests arrive on valid/ready channels and are arbitrated round-robin.
// The winner's control code and operands are latched into an operand register
// that drives the ALU. One cycle later the ALU result is captured into the
// winner's response register, which is offered on a valid/ready response
// channel. Only one operation is in flight at a time, so throughput is one
// operation per three cycles.
//
// Parameters
//   DATA_WIDTH  operand / result width
//   CTRL_WIDTH  ALU control code width
//
// Ports
//   clk                      clock, rising-edge active
//   reset                    asynchronous active-high reset
//   req0_valid / req1_valid  request pending
//   req0_ready / req1_ready  request accepted this cycle (combinational)
//   req0_ctrl  / req1_ctrl   ALU control code
//   req0_a, req0_b / req1_a, req1_b   operands (in1, in2)
//   rsp0_valid / rsp1_valid  result available
//   rsp0_ready / rsp1_ready  requester takes the result
//   rsp0_out   / rsp1_out    captured ALU out
//   rsp0_cmp   / rsp1_cmp    captured ALU compare
//   alu_ctrl, alu_in1, alu_in2   to the ALU
//   alu_out, alu_cmp             from the ALU
//   busy                     high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,

    // Requester 0
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [CTRL_WIDTH-1:0] req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,

    // Requester 1
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [CTRL_WIDTH-1:0] req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,

    // Response 0
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_out,
    output logic                  rsp0_cmp,

    // Response 1
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_out,
    output logic                  rsp1_cmp,

    // Shared ALU
    output logic [CTRL_WIDTH-1:0] alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_cmp,

    output logic                  busy
);

    // ALU "F" code presented while no operation has been granted since reset.
    localparam logic [CTRL_WIDTH-1:0] CtrlReset = CTRL_WIDTH'(5'b01001);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Index of the requester granted most recently; resets to 1 so that
    // requester 0 wins the first tie.
    logic rr_last_q;

    // Index of the requester that owns the in-flight operation.
    logic grant_q;

    // Operand register feeding the ALU. Retained after completion so the ALU
    // inputs change only on a new grant.
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic [DATA_WIDTH-1:0] in1_q;
    logic [DATA_WIDTH-1:0] in2_q;

    // Response registers, one set per requester.
    logic                  rsp0_valid_q;
    logic [DATA_WIDTH-1:0] rsp0_out_q;
    logic                  rsp0_cmp_q;
    logic                  rsp1_valid_q;
    logic [DATA_WIDTH-1:0] rsp1_out_q;
    logic                  rsp1_cmp_q;

    // Arbitration and handshake decode
    logic winner;      // requester that would be granted this cycle
    logic accept;      // request handshake this cycle
    logic capture;     // ALU result captured this cycle
    logic rsp_done;    // response handshake this cycle

    // -----------------------------------------------------------------------
    // Round-robin arbitration. On a tie the requester not granted last wins;
    // otherwise the single valid requester wins. Ready depends only on state,
    // the pointer and both request valids.
    // -----------------------------------------------------------------------
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~rr_last_q;
        end else begin
            winner = req1_valid;
        end
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == StIdle) begin
            req0_ready = req0_valid && (winner == 1'b0);
            req1_ready = req1_valid && (winner == 1'b1);
        end
    end

    assign accept  = req0_ready || req1_ready;
    assign capture = (state_q == StExec);

    // Response handshake for whichever requester owns the operation.
    always_comb begin
        rsp_done = 1'b0;
        if (state_q == StResp) begin
            rsp_done = grant_q ? (rsp1_valid_q && rsp1_ready)
                               : (rsp0_valid_q && rsp0_ready);
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Grant bookkeeping and operand register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
            grant_q   <= 1'b0;
            ctrl_q    <= CtrlReset;
            in1_q     <= '0;
            in2_q     <= '0;
        end else if (accept) begin
            rr_last_q <= winner;
            grant_q   <= winner;
            if (winner) begin
                ctrl_q <= req1_ctrl;
                in1_q  <= req1_a;
                in2_q  <= req1_b;
            end else begin
                ctrl_q <= req0_ctrl;
                in1_q  <= req0_a;
                in2_q  <= req0_b;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response registers. Only the granted requester's set is ever touched;
    // data is held from capture until the next capture for that requester.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid_q <= 1'b0;
            rsp0_out_q   <= '0;
            rsp0_cmp_q   <= 1'b0;
        end else if (grant_q == 1'b0) begin
            if (capture) begin
                rsp0_valid_q <= 1'b1;
                rsp0_out_q   <= alu_out;
                rsp0_cmp_q   <= alu_cmp;
            end else if (rsp_done) begin
                rsp0_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp1_valid_q <= 1'b0;
            rsp1_out_q   <= '0;
            rsp1_cmp_q   <= 1'b0;
        end else if (grant_q == 1'b1) begin
            if (capture) begin
                rsp1_valid_q <= 1'b1;
                rsp1_out_q   <= alu_out;
                rsp1_cmp_q   <= alu_cmp;
            end else if (rsp_done) begin
                rsp1_valid_q <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign alu_ctrl   = ctrl_q;
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_out   = rsp0_out_q;
    assign rsp0_cmp   = rsp0_cmp_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_out   = rsp1_out_q;
    assign rsp1_cmp   = rsp1_cmp_q;

    assign busy       = (state_q != StIdle);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters, e.g. the execute stage (port 0) and the branch-resolution unit (port 1). Each requester presents an operation code and two operands on a valid/ready request channel. The block arbitrates round-robin and latches the winner's operands onto the ALU inputs. It captures the ALU's `out`/`compare` results into a per-requester response register with a valid/ready response channel. Only one operation is in flight at a time.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `CTRL_WIDTH`, 5, ALU control code width
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  request pending
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle (combinational)
- `req0_ctrl` / `req1_ctrl`  in  CTRL_WIDTH  ALU control code
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_WIDTH  operands (in1, in2)
- `rsp0_valid` / `rsp1_valid`  out  1  result available
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes result
- `rsp0_out` / `rsp1_out`  out  DATA_WIDTH  captured ALU `out`
- `rsp0_cmp` / `rsp1_cmp`  out  1  captured ALU `compare`
- `alu_ctrl`  out  CTRL_WIDTH  to ALU `control`
- `alu_in1`, `alu_in2`  out  DATA_WIDTH  to ALU `in1`, `in2`
- `alu_out`  in  DATA_WIDTH  from ALU `out`
- `alu_cmp`  in  1  from ALU `compare`
- `busy`  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `reqN_valid` is high, select a winner and assert only its `reqN_ready`.
  - On the handshake, latch `ctrl`/`a`/`b` into the operand register and record the granted index `g`.
  - Update the round-robin pointer to `g` and go to EXEC.
- EXEC:
  - The operand register drives `alu_ctrl`/`alu_in1`/`alu_in2`.
  - At the clock edge, capture `alu_out` → `rspg_out` and `alu_cmp` → `rspg_cmp`, set `rspg_valid`, and go to RESP.
- RESP:
  - Hold `rspg_valid` and the data stable until `rspg_ready`.
  - On the handshake, clear `rspg_valid` and go to IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The pointer resets to "last = 1", so requester 0 wins the first tie.
- Both `req*_ready` are 0 outside IDLE. A request arriving while busy waits with `valid` held.
- The operand register retains its last values after completion; the ALU inputs change only on a new grant.
- Control codes are passed through unmodified, including codes 5'b10111–5'b11111 (the ALU returns 0/0 for these).
- The response registers of the non-granted requester are never modified.
- Reset (asynchronous, any state):
  - state = IDLE, rr pointer = 1.
  - `alu_ctrl` = 5'b01001 (F), `alu_in1` = `alu_in2` = 0.
  - `rsp*_valid` = 0, `rsp*_out` = 0, `rsp*_cmp` = 0, `busy` = 0.
  - The in-flight operation is discarded and no response is produced.

## Timing
- Request handshake at edge N. EXEC during cycle N→N+1. `rspg_valid` high from edge N+1.
- Latency is 1 cycle from acceptance to result visible.
- With `rsp_ready` held high, the response handshake occurs at edge N+2 and IDLE is re-entered.
- The earliest next acceptance is at edge N+3, so throughput is 1 operation per 3 cycles.
- `reqN_ready` depends combinationally on state, the rr pointer and both `req*_valid`. It has no dependence on `rsp*_ready`.
- A requester must hold its request fields stable while `valid` is high and `ready` is low.
- `rspN_ready` asserted while `rspN_valid` = 0 has no effect.
- The ALU is combinational and must settle within one cycle. No multicycle path is allowed.

## Test plan
- **Single operation:** after reset, req0 {ctrl=00000, a=5, b=7} with `rsp0_ready` = 1.
  - `req0_ready` high at the accept edge N.
  - `rsp0_valid` high from N+1, with `rsp0_out` = 12 and `rsp0_cmp` = 0.
  - `busy` high for exactly 2 cycles.
- **Tie arbitration:** both requesters valid continuously, req0 {00001, 9, 4}, req1 {01010, 3, 3}.
  - Grant order is 0, 1, 0, 1.
  - Responses: `rsp0_out` = 5; `rsp1_out` = 1 with `rsp1_cmp` = 1.
- **Backpressure:** req0 result with `rsp0_ready` = 0 for 5 cycles while req1 is valid.
  - `rsp0_valid`/data are held stable and `req1_ready` stays 0.
  - After `rsp0_ready` rises, req1 is accepted one cycle after IDLE is re-entered.
- **Branch code:** req1 {10010 (BLTZ), a=32'hFFFFFFFF, b=0}.
  - `rsp1_cmp` = 1, `rsp1_out` = 0.
  - Repeat with a=1: `rsp1_cmp` = 0.
- **Reset mid-operation:** assert `reset` during EXEC.
  - Immediately: `busy` = 0, `rsp*_valid` = 0, `alu_ctrl` = 01001, `alu_in*` = 0.
  - After release with both requesters valid, req0 is granted first.
- **Idle stability:** no requests for 10 cycles after a completed op {00111, 6, 3}.
  - `alu_ctrl`/`alu_in*` retain 00111/6/3.
  - `busy` = 0 and no `rsp_valid` pulses occur.
